// File: rtl/inv_key_expansion_if.sv
// ---------------------------------------------------------------------------
// inv_key_expansion_if
// Handshake/data bundle between the inverse-cipher control and the reverse
// AES-128 round-key generator.
//   start        master->slave  1-cycle pulse, load key_in and restart sequence
//   key_in       master->slave  128b key {w0,w1,w2,w3}, w0 = [127:96]
//   step         master->slave  request previous round key (honoured when ready)
//   round_key_o  slave->master  current round key
//   round_o      slave->master  round index of round_key_o (10..0)
//   ready        slave->master  round_key_o valid, step can be accepted
//   busy         slave->master  derivation / precompute in progress
// ---------------------------------------------------------------------------
interface inv_key_expansion_if;
   logic         start;
   logic [127:0] key_in;
   logic         step;
   logic [127:0] round_key_o;
   logic [3:0]   round_o;
   logic         ready;
   logic         busy;

   modport master (
      output start, key_in, step,
      input  round_key_o, round_o, ready, busy
   );

   modport slave (
      input  start, key_in, step,
      output round_key_o, round_o, ready, busy
   );
endinterface

// File: rtl/inv_key_expansion.sv
// ---------------------------------------------------------------------------
// inv_key_expansion
// Reverse-order AES-128 round-key generator for the decryption datapath.
// Loads the round-10 key, then each accepted step derives the previous round
// key (round r -> r-1) using one shared byte-serial S-box: 4 SUB cycles plus
// 1 COMMIT cycle per step.
// Optional feature macro FWD_PRECOMPUTE_EN: key_in is the cipher (round-0)
// key and the block first runs 10 forward expansions (5 cycles each, PRECOMP
// state) to reach the round-10 key before becoming ready.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears all state and outputs)
//   kx     inv_key_expansion_if.slave (start, key_in, step / round_key_o,
//          round_o, ready, busy)
// ---------------------------------------------------------------------------
module inv_key_expansion #(
   parameter int NR    = 10,
   parameter int KEY_W = 128
) (
   input logic                clk,
   input logic                rst_n,
   inv_key_expansion_if.slave kx
);

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   // Forward AES S-box, entry i at bits [8*(255-i) +: 8]
   localparam logic [2047:0] SBOX_FLAT = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_READY,
      S_SUB,
`ifdef FWD_PRECOMPUTE_EN
      S_COMMIT,
      S_PRECOMP
`else
      S_COMMIT
`endif
   } state_t;

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX_FLAT[{~a, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [KEY_W-1:0] round_key_q;
   logic [3:0]       round_q;
   logic [2:0]       cnt_q;
   logic [7:0]       sub_q [4];

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] t, rot, sub_word, sub_src;
   logic [7:0]  sbox_in, sbox_out;

   assign w0 = round_key_q[127:96];
   assign w1 = round_key_q[95:64];
   assign w2 = round_key_q[63:32];
   assign w3 = round_key_q[31:0];

   // w3 of the previous round is w3^w2; its RotWord feeds the S-box
   assign t        = w3 ^ w2;
   assign rot      = {t[23:0], t[31:24]};
   assign sub_word = {sub_q[0], sub_q[1], sub_q[2], sub_q[3]};

   // Byte cnt of the selected word, byte 0 being the most significant
   always_comb begin
      sub_src = rot;
`ifdef FWD_PRECOMPUTE_EN
      if (state_q == S_PRECOMP) sub_src = {w3[23:0], w3[31:24]};
`endif
      sbox_in  = sub_src[{~cnt_q[1:0], 3'b000} +: 8];
      sbox_out = sbox(sbox_in);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      kx.ready = 1'b0;
      kx.busy  = 1'b0;
      if (kx.start) begin
         state_d = S_LOAD;
      end else begin
         case (state_q)
            S_IDLE:   state_d = S_IDLE;
`ifdef FWD_PRECOMPUTE_EN
            S_LOAD:   state_d = S_PRECOMP;
            S_PRECOMP:
               if (cnt_q == 3'd4 && round_q == LAST_ROUND - 4'd1) state_d = S_READY;
`else
            S_LOAD:   state_d = S_READY;
`endif
            S_READY:  if (kx.step && round_q != 4'd0) state_d = S_SUB;
            S_SUB:    if (cnt_q == 3'd3) state_d = S_COMMIT;
            S_COMMIT: state_d = S_READY;
            default:  state_d = S_IDLE;
         endcase
      end
      case (state_q)
         S_READY:   kx.ready = 1'b1;
         S_SUB:     kx.busy  = 1'b1;
         S_COMMIT:  kx.busy  = 1'b1;
`ifdef FWD_PRECOMPUTE_EN
         S_LOAD:    kx.busy  = 1'b1;
         S_PRECOMP: kx.busy  = 1'b1;
`endif
         default: begin
            kx.ready = 1'b0;
            kx.busy  = 1'b0;
         end
      endcase
   end

   // Key datapath; start overrides everything and restarts from key_in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round_key_q <= '0;
         round_q     <= 4'd0;
         cnt_q       <= 3'd0;
         for (int i = 0; i < 4; i++) sub_q[i] <= 8'h00;
      end else if (kx.start) begin
         round_key_q <= kx.key_in;
`ifdef FWD_PRECOMPUTE_EN
         round_q     <= 4'd0;
`else
         round_q     <= LAST_ROUND;
`endif
         cnt_q       <= 3'd0;
         for (int i = 0; i < 4; i++) sub_q[i] <= 8'h00;
      end else begin
         case (state_q)
            S_SUB: begin
               sub_q[cnt_q[1:0]] <= sbox_out;
               cnt_q             <= (cnt_q == 3'd3) ? 3'd0 : cnt_q + 3'd1;
            end
            S_COMMIT: begin
               round_key_q <= {w0 ^ sub_word ^ {rcon(round_q - 4'd1), 24'h0},
                               w1 ^ w0, w2 ^ w1, w3 ^ w2};
               round_q     <= round_q - 4'd1;
               cnt_q       <= 3'd0;
            end
`ifdef FWD_PRECOMPUTE_EN
            S_PRECOMP: begin
               if (cnt_q == 3'd4) begin
                  // Forward expansion: each new word chains off the one before
                  round_key_q <= {w0 ^ sub_word ^ {rcon(round_q), 24'h0},
                                  w1 ^ w0 ^ sub_word ^ {rcon(round_q), 24'h0},
                                  w2 ^ w1 ^ w0 ^ sub_word ^ {rcon(round_q), 24'h0},
                                  w3 ^ w2 ^ w1 ^ w0 ^ sub_word ^ {rcon(round_q), 24'h0}};
                  round_q     <= round_q + 4'd1;
                  cnt_q       <= 3'd0;
               end else begin
                  sub_q[cnt_q[1:0]] <= sbox_out;
                  cnt_q             <= cnt_q + 3'd1;
               end
            end
`endif
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign kx.round_key_o = round_key_q;
   assign kx.round_o     = round_q;

endmodule

// File: tb/tb_inv_key_expansion.sv
module tb_inv_key_expansion;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   inv_key_expansion_if kxif ();

   inv_key_expansion dut (
      .clk  (clk),
      .rst_n(rst_n),
      .kx   (kxif)
   );

`ifdef FWD_PRECOMPUTE_EN
   localparam int LOAD_LAT = 51;
`else
   localparam int LOAD_LAT = 1;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]   sb [256];
   logic [127:0] rk_m [11];

   typedef struct {
      logic [127:0] cipher;
      logic [127:0] key10;
      int           steps;
      logic [3:0]   exp_round;
      logic [127:0] exp_key;
   } vec_t;
   vec_t vecs [5];

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return p;
   endfunction

   // Reference S-box from its definition: GF(2^8) inverse then affine map
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h01;
         for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
         sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   // Forward key schedule from the cipher key; rk_m[r] = round r key
   task automatic expand(input logic [127:0] c);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = c[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
            rc  = xtime(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] feed_for(input logic [127:0] cipher, input logic [127:0] key10);
`ifdef FWD_PRECOMPUTE_EN
      return cipher;
`else
      return key10;
`endif
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input int max, input string name);
      int i = 0;
      while (kxif.ready !== 1'b1 && i < max) begin
         @(negedge clk);
         i++;
      end
      if (kxif.ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: ready not seen within %0d cycles", name, max);
      end
   endtask

   task automatic start_key(input logic [127:0] k);
      @(negedge clk);
      kxif.start  = 1'b1;
      kxif.key_in = k;
      @(negedge clk);
      kxif.start  = 1'b0;
   endtask

   task automatic pulse_step();
      @(negedge clk);
      kxif.step = 1'b1;
      @(negedge clk);
      kxif.step = 1'b0;
   endtask

   localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   initial begin
      logic [127:0] c;
      kxif.start  = 1'b0;
      kxif.step   = 1'b0;
      kxif.key_in = '0;
      build_sbox();
      vecs[0] = '{K0, K10, 0,  4'd10, K10};
      vecs[1] = '{K0, K10, 1,  4'd9,  K9};
      vecs[2] = '{K0, K10, 9,  4'd1,  K1};
      vecs[3] = '{K0, K10, 10, 4'd0,  K0};
      vecs[4] = '{K0, K10, 11, 4'd0,  K0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", 128'(kxif.ready), 128'd0);
      chk("rst_busy",  128'(kxif.busy),  128'd0);
      chk("rst_round", 128'(kxif.round_o), 128'd0);
      chk("rst_key",   kxif.round_key_o, 128'd0);
      rst_n = 1'b1;

      // Load latency and loaded key
      start_key(feed_for(K0, K10));
      repeat (LOAD_LAT - 1) @(negedge clk);
      chk("load_ready_early", 128'(kxif.ready), 128'd0);
      @(negedge clk);
      chk("load_ready", 128'(kxif.ready), 128'd1);
      chk("load_round", 128'(kxif.round_o), 128'd10);
      chk("load_key",   kxif.round_key_o, K10);

      // One step: exact 5-cycle latency, key held during SUB
      pulse_step();
      chk("step_busy",  128'(kxif.busy),  128'd1);
      chk("step_ready", 128'(kxif.ready), 128'd0);
      repeat (4) @(negedge clk);
      chk("step_hold_key",  kxif.round_key_o, K10);
      chk("step_ready_early", 128'(kxif.ready), 128'd0);
      @(negedge clk);
      chk("step_ready_done", 128'(kxif.ready), 128'd1);
      chk("step_round", 128'(kxif.round_o), 128'd9);
      chk("step_key",   kxif.round_key_o, K9);

      // Table of known-answer step counts
      for (int v = 0; v < 5; v++) begin
         start_key(feed_for(vecs[v].cipher, vecs[v].key10));
         wait_ready(80, "tbl_load");
         for (int s = 0; s < vecs[v].steps; s++) begin
            pulse_step();
            wait_ready(20, "tbl_step");
         end
         chk($sformatf("tbl%0d_round", v), 128'(kxif.round_o), 128'(vecs[v].exp_round));
         chk($sformatf("tbl%0d_key", v),   kxif.round_key_o, vecs[v].exp_key);
         chk($sformatf("tbl%0d_busy", v),  128'(kxif.busy), 128'd0);
      end

      // Random cipher keys against the forward-schedule model
      for (int k = 0; k < 4; k++) begin
         c = {$urandom(), $urandom(), $urandom(), $urandom()};
         expand(c);
         start_key(feed_for(c, rk_m[10]));
         wait_ready(80, "rnd_load");
         chk("rnd_key10", kxif.round_key_o, rk_m[10]);
         for (int r = 9; r >= 0; r--) begin
            pulse_step();
            wait_ready(20, "rnd_step");
            chk($sformatf("rnd%0d_key%0d", k, r), kxif.round_key_o, rk_m[r]);
            chk($sformatf("rnd%0d_round%0d", k, r), 128'(kxif.round_o), 128'(r));
         end
         pulse_step();
         @(negedge clk);
         chk("rnd_extra_round", 128'(kxif.round_o), 128'd0);
         chk("rnd_extra_key",   kxif.round_key_o, rk_m[0]);
      end

      // Steps during SUB are dropped, not queued
      expand(K0);
      start_key(feed_for(K0, K10));
      wait_ready(80, "drop_load");
      pulse_step();
      @(negedge clk);
      kxif.step = 1'b1;
      repeat (2) @(negedge clk);
      kxif.step = 1'b0;
      wait_ready(20, "drop_step");
      chk("drop_round", 128'(kxif.round_o), 128'd9);
      chk("drop_key",   kxif.round_key_o, K9);
      repeat (8) @(negedge clk);
      chk("drop_noqueue_round", 128'(kxif.round_o), 128'd9);
      chk("drop_noqueue_ready", 128'(kxif.ready), 128'd1);

      // start 2 cycles into SUB aborts and reloads
      c = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(c);
      pulse_step();
      @(negedge clk);
      kxif.start  = 1'b1;
      kxif.key_in = feed_for(c, rk_m[10]);
      @(negedge clk);
      kxif.start  = 1'b0;
      wait_ready(80, "abort_load");
      chk("abort_round", 128'(kxif.round_o), 128'd10);
      chk("abort_key",   kxif.round_key_o, rk_m[10]);
      pulse_step();
      wait_ready(20, "abort_step");
      chk("abort_step_key", kxif.round_key_o, rk_m[9]);

      // Asynchronous reset during COMMIT
      pulse_step();
      repeat (4) @(negedge clk);
      chk("commit_busy", 128'(kxif.busy), 128'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_ready", 128'(kxif.ready), 128'd0);
      chk("arst_busy",  128'(kxif.busy),  128'd0);
      chk("arst_round", 128'(kxif.round_o), 128'd0);
      chk("arst_key",   kxif.round_key_o, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      kxif.step = 1'b1;
      repeat (6) @(negedge clk);
      kxif.step = 1'b0;
      chk("post_rst_ready", 128'(kxif.ready), 128'd0);
      chk("post_rst_round", 128'(kxif.round_o), 128'd0);
      chk("post_rst_key",   kxif.round_key_o, 128'd0);
      start_key(feed_for(K0, K10));
      wait_ready(80, "post_rst_load");
      chk("post_rst_reload", kxif.round_key_o, K10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
